i2c_cmd_sequencer: RTL and testbench

- Parametrised I2C-master write sequencer for codec bring-up (WM8731-class audio codec).
- Streams NUM_CMDS 16-bit register words from an external command table to one 7-bit device address: START, addr+W, data-hi, data-lo, STOP per command.
- Programmable SCL rate and ACK-slot handling; sits between top-level init control and the open-drain I2C pads.

---
 rtl/i2c_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: I2C-master write sequencer for codec bring-up.
// For each of NUM_CMDS table words, issues START, {DEV_ADDR,W}, data-hi,
// data-lo, STOP. Each quarter of an SCL bit lasts CLK_DIV clocks.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           run request (level), honoured only in IDLE/DONE/ERR
//   i_cmd_data[15:0]  table word for o_cmd_idx (combinational external ROM)
//   i_sdat            SDA pad readback
//   o_cmd_idx[7:0]    current command index
//   o_sclk, o_sdat    SCL drive, SDA drive value
//   o_oen             1 = master drives SDA, 0 = released (ACK slot)
//   o_busy            high from START through the last STOP
//   o_finished        all commands sent
//   o_error           NACK retries exhausted
//   o_state[2:0]      FSM state
//
// Optional feature macro: ACK_CHECK_EN. When defined, a 1 sampled in an ACK
// slot is a NACK: the frame is stopped and the command retried up to
// MAX_RETRY attempts in total, then the FSM parks in ERR. When undefined,
// i_sdat is ignored and ERR is unreachable.
module i2c_cmd_sequencer #(
    parameter int unsigned NUM_CMDS  = 10,
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_cmd_data,
    input  logic        i_sdat,
    output logic [7:0]  o_cmd_idx,
    output logic        o_sclk,
    output logic        o_sdat,
    output logic        o_oen,
    output logic        o_busy,
    output logic        o_finished,
    output logic        o_error,
    output logic [2:0]  o_state
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SHIFT_W = 24;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       IDX_LAST   = 8'(NUM_CMDS - 1);
    localparam logic [7:0]       RETRY_LAST = 8'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [DIV_W-1:0]     div, div_n;
    logic [1:0]           qtr, qtr_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [1:0]           byte_idx, byte_idx_n;
    logic [SHIFT_W-1:0]   shift, shift_n;
    logic [7:0]           retry, retry_n;
    logic                 nack, nack_n;
    logic [7:0]           cmd_idx_n;
    logic                 finished_n, error_n, busy_n;
    logic                 sclk_n, sdat_n, oen_n;
    logic                 tick;
    logic                 ack_sample;

`ifdef ACK_CHECK_EN
    assign ack_sample = i_sdat;
`else
    logic unused_sdat;
    assign unused_sdat = i_sdat;
    assign ack_sample  = 1'b0;
`endif

    assign o_state = state;

    // State, counters and registered pad/status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            div        <= '0;
            qtr        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            retry      <= '0;
            nack       <= 1'b0;
            o_cmd_idx  <= '0;
            o_finished <= 1'b0;
            o_error    <= 1'b0;
            o_busy     <= 1'b0;
            o_sclk     <= 1'b1;
            o_sdat     <= 1'b1;
            o_oen      <= 1'b1;
        end else begin
            state      <= state_n;
            div        <= div_n;
            qtr        <= qtr_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            shift      <= shift_n;
            retry      <= retry_n;
            nack       <= nack_n;
            o_cmd_idx  <= cmd_idx_n;
            o_finished <= finished_n;
            o_error    <= error_n;
            o_busy     <= busy_n;
            o_sclk     <= sclk_n;
            o_sdat     <= sdat_n;
            o_oen      <= oen_n;
        end
    end

    // Next-state logic; pad outputs are decoded from the next state so they
    // line up with the state register instead of lagging a cycle.
    always_comb begin
        state_n    = state;
        div_n      = '0;
        qtr_n      = qtr;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        shift_n    = shift;
        retry_n    = retry;
        nack_n     = nack;
        cmd_idx_n  = o_cmd_idx;
        finished_n = o_finished;
        error_n    = o_error;
        tick       = (div == DIV_LAST);

        if (state inside {START, SHIFT, ACK, STOP}) begin
            div_n = tick ? '0 : DIV_W'(div + 1'b1);
        end

        case (state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    state_n    = START;
                    qtr_n      = '0;
                    bit_idx_n  = 3'd7;
                    byte_idx_n = '0;
                    retry_n    = '0;
                    nack_n     = 1'b0;
                    cmd_idx_n  = '0;
                    finished_n = 1'b0;
                    error_n    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (qtr == 2'd0) begin
                        // Latched after q0 so the ROM has seen the new index.
                        qtr_n   = 2'd1;
                        shift_n = {DEV_ADDR, 1'b0, i_cmd_data};
                    end else begin
                        qtr_n   = '0;
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (qtr == 2'd3) begin
                        qtr_n   = '0;
                        shift_n = {shift[SHIFT_W-2:0], 1'b0};
                        if (bit_idx == 3'd0) begin
                            state_n = ACK;
                        end else begin
                            bit_idx_n = bit_idx - 3'd1;
                        end
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            ACK: begin
                if (tick) begin
                    if (qtr == 2'd2) begin
                        nack_n = nack | ack_sample;
                    end
                    if (qtr == 2'd3) begin
                        qtr_n = '0;
                        if (nack || byte_idx == 2'd2) begin
                            state_n = STOP;
                        end else begin
                            byte_idx_n = byte_idx + 2'd1;
                            bit_idx_n  = 3'd7;
                            state_n    = SHIFT;
                        end
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (qtr == 2'd2) begin
                        qtr_n      = '0;
                        bit_idx_n  = 3'd7;
                        byte_idx_n = '0;
                        nack_n     = 1'b0;
                        if (nack) begin
                            if (retry < RETRY_LAST) begin
                                retry_n = retry + 8'd1;
                                state_n = START;
                            end else begin
                                error_n = 1'b1;
                                state_n = ERR;
                            end
                        end else if (o_cmd_idx == IDX_LAST) begin
                            finished_n = 1'b1;
                            state_n    = DONE;
                        end else begin
                            cmd_idx_n = o_cmd_idx + 8'd1;
                            retry_n   = '0;
                            state_n   = START;
                        end
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        sclk_n = 1'b1;
        sdat_n = 1'b1;
        oen_n  = 1'b1;
        case (state_n)
            START: sdat_n = (qtr_n == 2'd0);
            SHIFT: begin
                sclk_n = qtr_n[1];
                sdat_n = shift_n[SHIFT_W-1];
            end
            ACK: begin
                sclk_n = qtr_n[1];
                oen_n  = 1'b0;
            end
            STOP: begin
                sclk_n = (qtr_n != 2'd0);
                sdat_n = (qtr_n == 2'd2);
            end
            default: ;
        endcase
        busy_n = state_n inside {START, SHIFT, ACK, STOP};
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: a bus monitor decodes the I2C
// traffic and measures SCL/ACK-slot timing; a table-driven reference derives
// the expected byte stream, frame counts and run length from the command table.
module tb_i2c_cmd_sequencer;

    localparam int T_NUM   = 2;
    localparam int T_DIV   = 2;
    localparam int T_RETRY = 3;
    localparam logic [6:0] T_ADDR = 7'h1A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] cmd_data;
    logic        sda;
    logic [7:0]  o_cmd_idx;
    logic        o_sclk, o_sdat, o_oen, o_busy, o_finished, o_error;
    logic [2:0]  o_state;

    logic [15:0] table_mem [T_NUM];
    bit          nack_mode = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    i2c_cmd_sequencer #(
        .NUM_CMDS (T_NUM),
        .CLK_DIV  (T_DIV),
        .DEV_ADDR (T_ADDR),
        .MAX_RETRY(T_RETRY)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (i_start),
        .i_cmd_data(cmd_data),
        .i_sdat    (sda),
        .o_cmd_idx (o_cmd_idx),
        .o_sclk    (o_sclk),
        .o_sdat    (o_sdat),
        .o_oen     (o_oen),
        .o_busy    (o_busy),
        .o_finished(o_finished),
        .o_error   (o_error),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External command ROM
    always_comb begin
        cmd_data = 16'hDEAD;
        for (int k = 0; k < T_NUM; k++)
            if (o_cmd_idx == 8'(k)) cmd_data = table_mem[k];
    end

    // Bus monitor state
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_oen = 1'b1;
    logic [7:0] sh = '0;
    logic [7:0] got[$];
    logic [2:0] run_state = 3'd0;
    int bitcnt = 0, frame_bytes = 0, scl_run = 0, oen_run = 0;
    int n_starts = 0, n_stops = 0, n_ack_runs = 0, nacks_seen = 0;
    int scl_bad = 0, sda_bad = 0, ack_run_bad = 0;

    // Slave: ACKs everything except, in nack_mode, the address byte of command 1
    logic slave_sda;
    assign slave_sda = nack_mode && (o_cmd_idx == 8'd1) && (frame_bytes == 1);
    assign sda = o_oen ? o_sdat : slave_sda;

    always @(negedge clk) begin
        if (o_sclk && prev_scl && (sda != prev_sda)) begin
            if (!sda) begin
                n_starts++;
                bitcnt = 0;
                frame_bytes = 0;
            end else begin
                n_stops++;
            end
            if (o_state == 3'd2 || o_state == 3'd3) sda_bad++;
        end
        if (o_sclk && !prev_scl) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], sda};
                bitcnt++;
                if (bitcnt == 8) begin
                    got.push_back(sh);
                    frame_bytes++;
                end
            end else begin
                if (sda) nacks_seen++;
                bitcnt = 0;
            end
        end
        if (o_sclk != prev_scl) begin
            if ((run_state == 3'd2 || run_state == 3'd3) &&
                (o_state == 3'd2 || o_state == 3'd3) && scl_run != 2 * T_DIV)
                scl_bad++;
            scl_run = 1;
            run_state = o_state;
        end else begin
            scl_run++;
        end
        if (!o_oen) begin
            oen_run++;
        end else if (!prev_oen) begin
            n_ack_runs++;
            if (oen_run != 4 * T_DIV) ack_run_bad++;
            oen_run = 0;
        end
        prev_scl = o_sclk;
        prev_sda = sda;
        prev_oen = o_oen;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input bit hold, input bit nack);
        int b0, s0, p0, a0, n0, t0, t1, n;
        int exp_len, exp_acks, exp_starts, exp_nacks;
        bit exp_err;
        logic [7:0] exp_q[$];
        b0 = got.size(); s0 = n_starts; p0 = n_stops; a0 = n_ack_runs; n0 = nacks_seen;
        nack_mode = nack;

        // Reference: every command is addr+W, hi, lo; 113 quarters each
        exp_err = 1'b0;
        exp_nacks = 0;
        for (int k = 0; k < T_NUM; k++) begin
            exp_q.push_back({T_ADDR, 1'b0});
            exp_q.push_back(table_mem[k][15:8]);
            exp_q.push_back(table_mem[k][7:0]);
        end
        exp_len    = T_NUM * 113 * T_DIV;
        exp_acks   = 3 * T_NUM;
        exp_starts = T_NUM;
        if (nack) begin
`ifdef ACK_CHECK_EN
            // Command 0 completes; command 1 is addr-only frames (2+36+3 quarters)
            exp_q.delete();
            exp_q.push_back({T_ADDR, 1'b0});
            exp_q.push_back(table_mem[0][15:8]);
            exp_q.push_back(table_mem[0][7:0]);
            for (int r = 0; r < T_RETRY; r++) exp_q.push_back({T_ADDR, 1'b0});
            exp_len    = (113 + T_RETRY * 41) * T_DIV;
            exp_acks   = 3 + T_RETRY;
            exp_starts = 1 + T_RETRY;
            exp_nacks  = T_RETRY;
            exp_err    = 1'b1;
`else
            exp_nacks = 1;
`endif
        end

        i_start = 1'b1;
        @(negedge clk);
        if (!hold) i_start = 1'b0;
        n = 0;
        while (o_state !== 3'd1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("start_entry", 32'(o_state), 32'd1);
        t0 = cyc;
        check("busy_on", 32'(o_busy), 32'd1);
        check("finished_cleared", 32'(o_finished), 32'd0);
        check("error_cleared", 32'(o_error), 32'd0);
        check("idx_zero", 32'(o_cmd_idx), 32'd0);
        n = 0;
        while (!(o_finished || o_error) && n < 4000) begin
            @(negedge clk);
            n++;
            if (hold && (cyc - t0) >= 300) i_start = 1'b0;
        end
        i_start = 1'b0;
        t1 = cyc;
        check("run_cycles", 32'(t1 - t0), 32'(exp_len));
        check("finished", 32'(o_finished), 32'(!exp_err));
        check("error", 32'(o_error), 32'(exp_err));
        check("busy_off", 32'(o_busy), 32'd0);
        check("end_state", 32'(o_state), exp_err ? 32'd6 : 32'd5);
        check("end_idx", 32'(o_cmd_idx), exp_err ? 32'd1 : 32'(T_NUM - 1));
        check("bus_idle", 32'({o_sclk, o_sdat, o_oen}), 32'b111);
        check("byte_count", 32'(got.size() - b0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("byte%0d", i),
                  (b0 + i < got.size()) ? 32'(got[b0 + i]) : 32'hBAD, 32'(exp_q[i]));
        check("starts", 32'(n_starts - s0), 32'(exp_starts));
        check("stops", 32'(n_stops - p0), 32'(exp_starts));
        check("ack_slots", 32'(n_ack_runs - a0), 32'(exp_acks));
        check("nacks_seen", 32'(nacks_seen - n0), 32'(exp_nacks));
        check("scl_quarter_timing", 32'(scl_bad), 32'd0);
        check("sda_stable_scl_high", 32'(sda_bad), 32'd0);
        check("ack_slot_width", 32'(ack_run_bad), 32'd0);
        nack_mode = 1'b0;
    endtask

    initial begin
        int n;
        table_mem[0] = 16'h1201;
        table_mem[1] = 16'h0E42;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(o_sclk), 32'd1);
        check("rst_sdat", 32'(o_sdat), 32'd1);
        check("rst_oen", 32'(o_oen), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_finished", 32'(o_finished), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_idx", 32'(o_cmd_idx), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_without_start", 32'(o_state), 32'd0);

        // Directed table
        do_run(1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("done_hold_state", 32'(o_state), 32'd5);
        check("done_hold_finished", 32'(o_finished), 32'd1);

        // Random table, i_start held through the run
        for (int k = 0; k < T_NUM; k++) table_mem[k] = 16'($urandom);
        do_run(1'b1, 1'b0);

        // Random table, slave NACKs command 1 address byte
        for (int k = 0; k < T_NUM; k++) table_mem[k] = 16'($urandom);
        do_run(1'b0, 1'b1);

        // Asynchronous reset in the middle of a SHIFT low phase
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (!(o_state == 3'd2 && o_cmd_idx == 8'd1 && !o_sclk && !o_sdat) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_mid_shift", 32'(o_state), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_sclk", 32'(o_sclk), 32'd1);
        check("arst_sdat", 32'(o_sdat), 32'd1);
        check("arst_oen", 32'(o_oen), 32'd1);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_idx", 32'(o_cmd_idx), 32'd0);
        check("arst_state", 32'(o_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(o_state), 32'd0);
        check("post_rst_finished", 32'(o_finished), 32'd0);

        // Recovery run after the aborted frame
        for (int k = 0; k < T_NUM; k++) table_mem[k] = 16'($urandom);
        do_run(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
